// File: rtl/spi_sniff_pkg.sv
// spi_sniff_pkg: shared constants and output FSM encoding for the SPI frame packer
package spi_sniff_pkg;
  localparam logic [7:0] FRAME_SYNC = 8'hA5;
  localparam int FLAG_OVF = 0;
  localparam int FLAG_FORCED = 1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_H,
    ST_LEN_L,
    ST_FLAGS,
    ST_MOSI,
    ST_MISO
  } tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of 2^ADDR_W words with registered read data
// ports: push/wr_data write side, pop/rd_data read side (rd_data updates only on a pop), full/empty status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int ADDR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_data <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) begin
        rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end
endmodule

// File: rtl/spi_frame_packer.sv
// spi_frame_packer: buffers SPI transactions as (mosi,miso) pairs and emits each as an A5/LEN/FLAGS framed byte stream
// ports: cs_start/cs_end/data_valid + mosi_data/miso_data capture side; tx_data/tx_valid/tx_ready output stream;
//        drop_cnt counts discarded transactions; busy = frame open or committed frames still unsent
module spi_frame_packer
  import spi_sniff_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DESC_W = 2
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        cs_start,
  input  logic        cs_end,
  input  logic        data_valid,
  input  logic [7:0]  mosi_data,
  input  logic [7:0]  miso_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] drop_cnt,
  output logic        busy
);
  localparam int OW = DESC_W + 1;
  logic open, ovf, keep_pair, commit, slots_full;
  logic [15:0] pair_cnt, rem;
  logic [7:0] flags;
  logic [OW-1:0] outstanding;
  logic [15:0] pair_q;
  logic [23:0] desc_q;
  logic data_full, data_empty, desc_full, desc_empty;
  logic desc_pop, data_pop, frame_done, hs;
  tx_state_t state, nxt;
  assign keep_pair = open && data_valid && !data_full && pair_cnt != 16'hFFFF;
  assign commit = open && (cs_end || cs_start);
  // A slot is held from commit until the frame's last byte leaves, so the frame being emitted still counts.
  assign slots_full = (outstanding + OW'(commit)) == OW'(2 ** DESC_W);
  assign busy = open || outstanding != '0;
  assign hs = tx_valid && tx_ready;
  always_comb begin
    flags = '0;
    flags[FLAG_OVF] = ovf | (open && data_valid && !keep_pair);
    flags[FLAG_FORCED] = cs_start && !cs_end;
  end
  sync_fifo #(.WIDTH(16), .ADDR_W(ADDR_W)) u_data (
    .clk(clk_50m), .rst_n(rst_n),
    .push(keep_pair), .wr_data({mosi_data, miso_data}),
    .pop(data_pop && !data_empty), .rd_data(pair_q),
    .full(data_full), .empty(data_empty)
  );
  sync_fifo #(.WIDTH(24), .ADDR_W(DESC_W)) u_desc (
    .clk(clk_50m), .rst_n(rst_n),
    .push(commit && !desc_full), .wr_data({pair_cnt + 16'(keep_pair), flags}),
    .pop(desc_pop), .rd_data(desc_q),
    .full(desc_full), .empty(desc_empty)
  );
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      open <= 1'b0;
      ovf <= 1'b0;
      pair_cnt <= '0;
      drop_cnt <= '0;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + OW'(commit) - OW'(frame_done);
      if (cs_start) begin
        open <= !slots_full;
        pair_cnt <= '0;
        ovf <= 1'b0;
        if (slots_full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (commit) begin
        open <= 1'b0;
      end else begin
        if (keep_pair) pair_cnt <= pair_cnt + 16'd1;
        if (open && data_valid && !keep_pair) ovf <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rem <= '0;
    end else begin
      state <= nxt;
      if (state == ST_SYNC) rem <= desc_q[23:8];
      else if (state == ST_MISO && hs) rem <= rem - 16'd1;
    end
  end
  // Data FIFO pops happen one state ahead of MOSI so the registered pair is ready without a bubble.
  always_comb begin
    nxt = state;
    desc_pop = 1'b0;
    data_pop = 1'b0;
    frame_done = 1'b0;
    tx_valid = state != ST_IDLE;
    tx_data = 8'h00;
    case (state)
      ST_IDLE: if (!desc_empty) begin
        desc_pop = 1'b1;
        nxt = ST_SYNC;
      end
      ST_SYNC: begin
        tx_data = FRAME_SYNC;
        nxt = hs ? ST_LEN_H : state;
      end
      ST_LEN_H: begin
        tx_data = desc_q[23:16];
        nxt = hs ? ST_LEN_L : state;
      end
      ST_LEN_L: begin
        tx_data = desc_q[15:8];
        nxt = hs ? ST_FLAGS : state;
      end
      ST_FLAGS: begin
        tx_data = desc_q[7:0];
        if (hs) begin
          nxt = desc_q[23:8] == '0 ? ST_IDLE : ST_MOSI;
          frame_done = desc_q[23:8] == '0;
          data_pop = desc_q[23:8] != '0;
        end
      end
      ST_MOSI: begin
        tx_data = pair_q[15:8];
        nxt = hs ? ST_MISO : state;
      end
      ST_MISO: begin
        tx_data = pair_q[7:0];
        if (hs) begin
          nxt = rem > 16'd1 ? ST_MOSI : ST_IDLE;
          data_pop = rem > 16'd1;
          frame_done = rem <= 16'd1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_frame_packer.sv
// tb_spi_frame_packer: randomized and directed checks of spi_frame_packer against a frame-level reference model
module tb_spi_frame_packer;
  localparam int AW = 2;
  localparam int DW = 1;
  localparam int DN = 2;
  localparam int FN = 4;
  logic clk_50m = 0, rst_n = 0, cs_start = 0, cs_end = 0, data_valid = 0, tx_ready = 0;
  logic [7:0] mosi_data = 0, miso_data = 0, tx_data;
  logic tx_valid, busy;
  logic [15:0] drop_cnt;
  int n_cmp = 0, n_bad = 0;
  bit rand_rdy = 0;
  logic [7:0] exp_q[$];
  int frame_bytes_q[$];
  int frame_pairs_q[$];
  logic [15:0] m_pairs[$];
  bit m_open = 0, m_ovf = 0;
  int m_drop = 0;
  logic prev_stall = 0;
  logic [7:0] prev_data = 0;

  spi_frame_packer #(.ADDR_W(AW), .DESC_W(DW)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .cs_start(cs_start), .cs_end(cs_end),
    .data_valid(data_valid), .mosi_data(mosi_data), .miso_data(miso_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  function automatic int occupancy();
    int s = m_pairs.size();
    foreach (frame_pairs_q[i]) s += frame_pairs_q[i];
    return s;
  endfunction

  function automatic void m_commit(input bit forced);
    int n = m_pairs.size();
    exp_q.push_back(8'hA5);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
    exp_q.push_back({6'b0, forced, m_ovf});
    foreach (m_pairs[i]) begin
      exp_q.push_back(m_pairs[i][15:8]);
      exp_q.push_back(m_pairs[i][7:0]);
    end
    frame_bytes_q.push_back(4 + 2 * n);
    frame_pairs_q.push_back(n);
    m_open = 0;
  endfunction

  function automatic void m_start();
    if (m_open) m_commit(1);
    if (frame_bytes_q.size() == DN) begin
      m_open = 0;
      if (m_drop != 65535) m_drop++;
    end else begin
      m_open = 1;
      m_ovf = 0;
      m_pairs.delete();
    end
  endfunction

  function automatic void m_pair(input logic [7:0] m, input logic [7:0] s);
    if (!m_open) return;
    if (occupancy() < FN && m_pairs.size() < 65535) m_pairs.push_back({m, s});
    else m_ovf = 1;
  endfunction

  function automatic void m_reset();
    exp_q.delete();
    frame_bytes_q.delete();
    frame_pairs_q.delete();
    m_pairs.delete();
    m_open = 0;
    m_ovf = 0;
    m_drop = 0;
  endfunction

  task automatic cyc();
    @(posedge clk_50m);
    #1;
    if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start();
    m_start();
    cs_start = 1;
    cyc();
    cs_start = 0;
  endtask

  task automatic do_end();
    if (m_open) m_commit(0);
    cs_end = 1;
    cyc();
    cs_end = 0;
  endtask

  task automatic do_pair(input logic [7:0] m, input logic [7:0] s, input bit with_end);
    m_pair(m, s);
    if (with_end && m_open) m_commit(0);
    data_valid = 1;
    mosi_data = m;
    miso_data = s;
    cs_end = with_end;
    cyc();
    data_valid = 0;
    cs_end = 0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (!busy && exp_q.size() == 0) done = 1;
      else cyc();
    end
    chk("drain", {31'b0, done}, 1);
  endtask

  always @(negedge clk_50m) begin
    if (!rst_n) begin
      prev_stall <= 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'b0, tx_valid}, 1);
        chk("hold_data", {24'b0, tx_data}, {24'b0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        chk("byte_expected", {31'b0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          chk("byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
          if (frame_bytes_q.size() > 0) begin
            frame_bytes_q[0]--;
            if (frame_bytes_q[0] == 0) begin
              void'(frame_bytes_q.pop_front());
              void'(frame_pairs_q.pop_front());
            end
          end
        end
      end
      prev_stall <= tx_valid && !tx_ready;
      prev_data <= tx_data;
    end
  end

  initial begin
    int n, n1, n2;
    cyc();
    chk("rst_valid", {31'b0, tx_valid}, 0);
    chk("rst_data", {24'b0, tx_data}, 0);
    chk("rst_drop", {16'b0, drop_cnt}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    cyc();
    rst_n = 1;
    tx_ready = 1;
    cyc();
    do_start();
    do_pair(8'h9F, 8'h00, 0);
    do_pair(8'h00, 8'hEF, 0);
    do_end();
    chk("t1_early", {31'b0, tx_valid}, 0);
    cyc();
    chk("t1_sync_valid", {31'b0, tx_valid}, 1);
    chk("t1_sync_byte", {24'b0, tx_data}, 32'hA5);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t1_no_bubble", {31'b0, tx_valid}, 1);
    end
    cyc();
    chk("t1_idle", {31'b0, tx_valid}, 0);
    chk("t1_all_sent", exp_q.size(), 0);
    wait_drain();
    do_start();
    do_end();
    wait_drain();
    chk("t2_idle", {31'b0, tx_valid}, 0);
    tx_ready = 0;
    do_start();
    for (int i = 0; i < 6; i++) do_pair(8'($urandom), 8'($urandom), 0);
    do_end();
    repeat (3) cyc();
    chk("t3_stall_valid", {31'b0, tx_valid}, 1);
    chk("t3_stall_sync", {24'b0, tx_data}, 32'hA5);
    chk("t3_busy", {31'b0, busy}, 1);
    chk("t3_len4_ovf", {16'b0, exp_q[1], exp_q[2]}, 32'h0004);
    chk("t3_flags", {24'b0, exp_q[3]}, 32'h01);
    tx_ready = 1;
    wait_drain();
    do_start();
    do_pair(8'h11, 8'h22, 0);
    do_start();
    do_pair(8'h33, 8'h44, 0);
    do_end();
    wait_drain();
    tx_ready = 0;
    for (int k = 0; k < 3; k++) begin
      do_start();
      do_pair(8'($urandom), 8'($urandom), 0);
      do_end();
    end
    cyc();
    chk("t5_drop", {16'b0, drop_cnt}, 1);
    chk("t5_model_drop", {16'b0, drop_cnt}, m_drop);
    tx_ready = 1;
    wait_drain();
    rand_rdy = 1;
    do_start();
    for (int i = 0; i < 3; i++) do_pair(8'($urandom), 8'($urandom), 0);
    do_end();
    wait_drain();
    for (int k = 0; k < 25; k++) begin
      wait_drain();
      if ($urandom_range(0, 3) == 0) do_pair(8'($urandom), 8'($urandom), 0);
      if ($urandom_range(0, 5) == 0) do_end();
      n = $urandom_range(0, 6);
      do_start();
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) cyc();
        do_pair(8'($urandom), 8'($urandom), i == n - 1 && $urandom_range(0, 1) == 1);
      end
      if (m_open && $urandom_range(0, 3) == 0) begin
        n1 = n > FN ? FN : n;
        n2 = $urandom_range(0, FN - n1);
        do_start();
        for (int i = 0; i < n2; i++) do_pair(8'($urandom), 8'($urandom), 0);
      end
      if (m_open) do_end();
    end
    wait_drain();
    chk("rand_drop", {16'b0, drop_cnt}, m_drop);
    rand_rdy = 0;
    tx_ready = 0;
    do_start();
    for (int i = 0; i < 3; i++) do_pair(8'($urandom), 8'($urandom), 0);
    do_end();
    repeat (2) cyc();
    tx_ready = 1;
    repeat (3) cyc();
    rst_n = 0;
    m_reset();
    #1;
    chk("mid_rst_valid", {31'b0, tx_valid}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_data", {24'b0, tx_data}, 0);
    chk("mid_rst_drop", {16'b0, drop_cnt}, 0);
    cyc();
    rst_n = 1;
    cyc();
    chk("post_rst_valid", {31'b0, tx_valid}, 0);
    do_start();
    do_pair(8'h5A, 8'hC3, 1);
    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
